// File: rtl/sync_fifo_pkg.sv
// Shared constants, types and helpers for the parametrised synchronous FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: default geometry, {wr,rd} request encoding, clog2 constant function.
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Request decode of {wr_en, rd_en}
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RW   = 2'b11
  } req_e;

  // Ceiling log2, usable in parameter/localparam expressions
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param: write side, read side and status.
// Latency: n/a (wires only).
// Backpressure: full/empty tell the master when wr_en/rd_en will be ignored.
// Ports: master drives wr_en/data_in/rd_en; slave drives data_out/rd_valid/flags/count.
// With SYNC_FIFO_ERR_EN defined, adds err_clr (master) and overflow/underflow (slave).
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int AW = clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AW:0]       count;
`ifdef SYNC_FIFO_ERR_EN
  logic              err_clr;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, data_in, rd_en, err_clr,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, err_clr,
    output data_out, rd_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
`else
  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty, count
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, rd_valid, full, empty, almost_full, almost_empty, count
  );
`endif

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W simple dual-port storage array, no reset.
// Latency: write lands at the clock edge; read data registered, valid 1 cycle after rd_en_i.
// Backpressure: none; the caller only enables accepted accesses.
// Ports: clk; wr_en_i/wr_addr_i/wr_data_i write port; rd_en_i/rd_addr_i read port; rd_data_o.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    // Output register holds its value between reads
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and read-valid strobe.
// Latency: 1 cycle rd_en -> data_out/rd_valid; a written word is readable from the next edge.
// Backpressure: writes while full and reads while empty are dropped with no state change.
// Ports: clk, rst_n (async active-low); bus = sync_fifo_param_if.slave (write/read/status).
// Optional: define SYNC_FIFO_ERR_EN for sticky overflow/underflow flags cleared by err_clr.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_param_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              rd_valid_q, rd_valid_d;
  // Set by the first read after reset; masks the unreset memory output register
  logic              dout_seen_q, dout_seen_d;
  logic              full, empty;
  logic              wr_acc, rd_acc;
  req_e              req;
  logic [DATA_W-1:0] mem_rd_data;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Request decode: a request is only accepted when the FIFO can honour it
  assign req = req_e'({bus.wr_en, bus.rd_en});

  always_comb begin
    wr_acc = 1'b0;
    rd_acc = 1'b0;
    unique case (req)
      IDLE: ;
      RD:   rd_acc = ~empty;
      WR:   wr_acc = ~full;
      RW: begin
        // Empty: write only. Full: read only. Otherwise both.
        wr_acc = ~full;
        rd_acc = ~empty;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    rd_valid_d  = rd_acc;
    dout_seen_d = dout_seen_q | rd_acc;
    count_d     = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      dout_seen_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      dout_seen_q <= dout_seen_d;
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.data_in),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (mem_rd_data)
  );

  assign bus.data_out     = dout_seen_q ? mem_rd_data : '0;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky; a new error in the clearing cycle keeps the flag set
  assign ovf_d = (bus.wr_en & full)  | (ovf_q & ~bus.err_clr);
  assign udf_d = (bus.rd_en & empty) | (udf_q & ~bus.err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_W=8, DEPTH=16, AF=14, AE=2) with a data scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_sync_fifo_param;
  import sync_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) bus ();

  sync_fifo_param #(
    .DATA_W    (8),
    .DEPTH     (16),
    .AF_THRESH (14),
    .AE_THRESH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int        n_checks = 0;
  int        n_pass   = 0;
  int        mcount   = 0;
  logic [7:0] m_dout  = 8'h00;
  logic [7:0] sb [$];
  logic      m_ovf    = 1'b0;
  logic      m_udf    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_state();
    check("count",        32'(bus.count),        32'(mcount));
    check("full",         32'(bus.full),         32'(mcount == 16));
    check("empty",        32'(bus.empty),        32'(mcount == 0));
    check("almost_full",  32'(bus.almost_full),  32'(mcount >= 14));
    check("almost_empty", 32'(bus.almost_empty), 32'(mcount <= 2));
    check("data_out",     32'(bus.data_out),     32'(m_dout));
`ifdef SYNC_FIFO_ERR_EN
    check("overflow",     32'(bus.overflow),     32'(m_ovf));
    check("underflow",    32'(bus.underflow),    32'(m_udf));
`endif
  endtask

  // One clock of stimulus; inputs driven #1 after an edge, outputs checked #1 after the next
  task automatic step(input logic wr, input logic [7:0] din, input logic rd, input logic clr);
    logic wacc, racc;
    bus.wr_en   = wr;
    bus.data_in = din;
    bus.rd_en   = rd;
`ifdef SYNC_FIFO_ERR_EN
    bus.err_clr = clr;
`endif
    wacc  = wr && (mcount != 16);
    racc  = rd && (mcount != 0);
    m_ovf = (wr && mcount == 16) || (m_ovf && !clr);
    m_udf = (rd && mcount == 0)  || (m_udf && !clr);
    @(posedge clk);
    #1;
    if (racc) m_dout = sb.pop_front();
    if (wacc) sb.push_back(din);
    mcount = mcount + int'(wacc) - int'(racc);
    check("rd_valid", 32'(bus.rd_valid), 32'(racc));
    check_state();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
    bus.err_clr = 1'b0;
`endif
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = 8'h00;
`ifdef SYNC_FIFO_ERR_EN
    bus.err_clr = 1'b0;
`endif

    // Reset then idle
    #12;
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill with 00..0F, then a dropped 17th write
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("full_at_16", 32'(bus.full), 32'd1);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check("count_after_drop", 32'(bus.count), 32'd16);

    // Drain in order, then one read on empty
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_order", 32'(bus.data_out), 32'(i));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("hold_after_empty", 32'(bus.data_out), 32'h0F);
    check("no_valid_on_empty", 32'(bus.rd_valid), 32'd0);

    // Clear sticky errors, bring count to 5, then 40 cycles of simultaneous wr/rd
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h25 + i), 1'b1, 1'b0);
    check("count_steady_5", 32'(bus.count), 32'd5);

    // Empty with both requests: write only
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("empty_rw_count", 32'(bus.count), 32'd1);
    check("empty_rw_no_valid", 32'(bus.rd_valid), 32'd0);

    // Full with both requests: read only
    for (int i = 0; i < 15; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    check("full_rw_count", 32'(bus.count), 32'd15);
    check("full_rw_data", 32'(bus.data_out), 32'h77);

    // Async reset at count 9, between edges
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_reset_count", 32'(bus.count), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    mcount = 0;
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    check("async_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_reset_read", 32'(bus.data_out), 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
